// File: rtl/counter_sequencer.sv
// ----------------------------------------------------------------------------
// counter_sequencer
//
// Control sequencer for the 10-bit display counter. It conditions three raw
// board pushbuttons (2-FF synchronizer, debounce, press-edge detection) and
// drives the counter's active-low preload and direction controls. In BOUNCE
// mode the counter's own value is fed back so the direction flips at the end
// values (all ones while counting up, zero while counting down).
//
// Ports
//   clock_in         in   1      system clock
//   reset_n          in   1      asynchronous, active-low reset
//   key_preload_n    in   1      raw button, low = pressed: load SW value
//   key_reverse_n    in   1      raw button, low = pressed: toggle direction
//   key_mode_n       in   1      raw button, low = pressed: toggle MANUAL/BOUNCE
//   counter_value    in   CNT_W  visible counter value (feedback)
//   preload_combine  out  1      active-low preload strobe (one cycle)
//   reverse_combine  out  1      active-low direction: 0 = down, 1 = up
//   bounce_mode      out  1      1 = BOUNCE mode active
//   seq_state        out  2      FSM state: 0 UP, 1 DOWN, 2 PRELOAD
//
// Parameters
//   DEBOUNCE_CYCLES  cycles a synced key must hold a new level before it is
//                    accepted (must be >= 2)
//   CNT_W            width of the counter feedback
// ----------------------------------------------------------------------------
module counter_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 10
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             key_preload_n,
  input  logic             key_reverse_n,
  input  logic             key_mode_n,
  input  logic [CNT_W-1:0] counter_value,
  output logic             preload_combine,
  output logic             reverse_combine,
  output logic             bounce_mode,
  output logic [1:0]       seq_state
);

  // Debounce counter only has to reach DEBOUNCE_CYCLES-1.
  localparam int             DCW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DCW-1:0] DEB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DCW-1:0] DEB_ZERO = DCW'(0);
  localparam logic [DCW-1:0] DEB_ONE  = DCW'(1);

  // Key slot order inside the 3-bit key vectors.
  localparam int K_PRELOAD = 0;
  localparam int K_REVERSE = 1;
  localparam int K_MODE    = 2;

  typedef enum logic [1:0] {
    ST_UP      = 2'd0,
    ST_DOWN    = 2'd1,
    ST_PRELOAD = 2'd2
  } seq_state_t;

  // Input conditioning
  logic [2:0]     raw_keys_s;
  logic [2:0]     sync1_r;
  logic [2:0]     sync2_r;
  logic [2:0]     deb_r;        // accepted (debounced) level, 1 = released
  logic [2:0]     deb_d_r;      // accepted level one cycle ago
  logic [2:0]     press_evt_r;  // one-cycle pulse per accepted press
  logic [DCW-1:0] deb_cnt_r [0:2];

  // Sequencer
  seq_state_t state_r;
  seq_state_t state_nx_s;
  logic       preload_combine_r;
  logic       reverse_combine_r;
  logic       bounce_mode_r;
  logic       preload_nx_s;
  logic       reverse_nx_s;
  logic       bounce_nx_s;
  logic       preload_evt_s;
  logic       reverse_evt_s;
  logic       mode_evt_s;
  logic       at_top_s;
  logic       at_bottom_s;

  assign raw_keys_s = {key_mode_n, key_reverse_n, key_preload_n};

  // Two-stage synchronizer for the asynchronous button inputs.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 3'b111;
      sync2_r <= 3'b111;
    end else begin
      sync1_r <= raw_keys_s;
      sync2_r <= sync1_r;
    end
  end

  // Debounce: a synced level that differs from the accepted level must persist
  // for DEBOUNCE_CYCLES consecutive cycles; any return to the accepted level
  // restarts the count, so short glitches never get through.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      deb_r <= 3'b111;
      for (int i = 0; i < 3; i++) begin
        deb_cnt_r[i] <= DEB_ZERO;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2_r[i] == deb_r[i]) begin
          deb_cnt_r[i] <= DEB_ZERO;
        end else if (deb_cnt_r[i] == DEB_LAST) begin
          deb_r[i]     <= sync2_r[i];
          deb_cnt_r[i] <= DEB_ZERO;
        end else begin
          deb_cnt_r[i] <= deb_cnt_r[i] + DEB_ONE;
        end
      end
    end
  end

  // Press detection: registered pulse on an accepted 1->0 transition only.
  // Release edges and long holds produce nothing further.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      deb_d_r     <= 3'b111;
      press_evt_r <= 3'b000;
    end else begin
      deb_d_r     <= deb_r;
      press_evt_r <= deb_d_r & ~deb_r;
    end
  end

  assign preload_evt_s = press_evt_r[K_PRELOAD];
  assign reverse_evt_s = press_evt_r[K_REVERSE];
  assign mode_evt_s    = press_evt_r[K_MODE];

  // End-value detection uses only the visible CNT_W bits of the counter.
  assign at_top_s    = (counter_value == {CNT_W{1'b1}});
  assign at_bottom_s = (counter_value == {CNT_W{1'b0}});

  // Next-state and next-output logic. The counter keeps showing the end value
  // for a while after a bounce flip, but the opposite direction checks the
  // other end, so a flip cannot immediately undo itself.
  always_comb begin
    state_nx_s   = state_r;
    preload_nx_s = 1'b1;
    reverse_nx_s = reverse_combine_r;
    // Mode toggles in every state, including PRELOAD, independently of the
    // preload/reverse arbitration.
    bounce_nx_s  = bounce_mode_r ^ mode_evt_s;

    case (state_r)
      ST_UP: begin
        if (preload_evt_s) begin
          state_nx_s = ST_PRELOAD;
        end else if (reverse_evt_s) begin
          state_nx_s = ST_DOWN;
        end else if (bounce_mode_r && at_top_s) begin
          state_nx_s = ST_DOWN;
        end else begin
          state_nx_s = ST_UP;
        end
      end
      ST_DOWN: begin
        if (preload_evt_s) begin
          state_nx_s = ST_PRELOAD;
        end else if (reverse_evt_s) begin
          state_nx_s = ST_UP;
        end else if (bounce_mode_r && at_bottom_s) begin
          state_nx_s = ST_UP;
        end else begin
          state_nx_s = ST_DOWN;
        end
      end
      ST_PRELOAD: begin
        // One-cycle visit; preload/reverse pulses seen here are discarded.
        // The held direction output remembers where to return.
        if (reverse_combine_r) begin
          state_nx_s = ST_UP;
        end else begin
          state_nx_s = ST_DOWN;
        end
      end
      default: begin
        state_nx_s = ST_UP;
      end
    endcase

    // Outputs are decoded from the state being entered so they are registered
    // alongside it.
    case (state_nx_s)
      ST_UP: begin
        reverse_nx_s = 1'b1;
      end
      ST_DOWN: begin
        reverse_nx_s = 1'b0;
      end
      ST_PRELOAD: begin
        preload_nx_s = 1'b0;
      end
      default: begin
        reverse_nx_s = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_r           <= ST_UP;
      preload_combine_r <= 1'b1;
      reverse_combine_r <= 1'b1;
      bounce_mode_r     <= 1'b0;
    end else begin
      state_r           <= state_nx_s;
      preload_combine_r <= preload_nx_s;
      reverse_combine_r <= reverse_nx_s;
      bounce_mode_r     <= bounce_nx_s;
    end
  end

  assign preload_combine = preload_combine_r;
  assign reverse_combine = reverse_combine_r;
  assign bounce_mode     = bounce_mode_r;
  assign seq_state       = state_r;

endmodule
